// File: rtl/switch_port_p.sv
// Switch ingress port: buffers packets in a small FIFO, validates and classifies
// the head packet, requests the arbiter and transmits or drops it, with saturating statistics.
module switch_port_p #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ARB_TIMEOUT = 0,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in,
  output logic                          ready_in,
  input  logic [NUM_PORTS-1:0]          source_in,
  input  logic [NUM_PORTS-1:0]          target_in,
  input  logic [DATA_W-1:0]             data_in,
  output logic [NUM_PORTS-1:0]          req,
  input  logic                          grant,
  output logic                          valid_out,
  output logic [NUM_PORTS-1:0]          source_out,
  output logic [NUM_PORTS-1:0]          target_out,
  output logic [DATA_W-1:0]             data_out,
  output logic [1:0]                    pkt_type_out,
  output logic [CNT_W-1:0]              tx_cnt,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW     = $clog2(FIFO_DEPTH) + 1;
  localparam int EW     = DATA_W + 2 * NUM_PORTS;
  localparam int WAIT_W = (ARB_TIMEOUT > 1) ? $clog2(ARB_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((ARB_TIMEOUT > 0) ? ARB_TIMEOUT - 1 : 0);
  localparam bit TO_EN = (ARB_TIMEOUT > 0);

  localparam logic [1:0] PT_ERR = 2'b00;
  localparam logic [1:0] PT_UC  = 2'b01;
  localparam logic [1:0] PT_MC  = 2'b10;
  localparam logic [1:0] PT_BC  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROUTE    = 2'd1,
    ARB_WAIT = 2'd2,
    TRANSMIT = 2'd3
  } state_t;

  state_t                 state_q;
  logic [1:0]             type_q;
  logic [WAIT_W-1:0]      wait_q;
  logic [NUM_PORTS-1:0]   req_q;
  logic                   valid_out_q;
  logic [NUM_PORTS-1:0]   source_out_q;
  logic [NUM_PORTS-1:0]   target_out_q;
  logic [DATA_W-1:0]      data_out_q;
  logic [1:0]             pkt_type_q;
  logic [CNT_W-1:0]       tx_cnt_q;
  logic [CNT_W-1:0]       drop_cnt_q;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [LW-1:0]          count_q;
  logic [LW-1:0]          count_d;

  logic                   push_s;
  logic                   pop_s;
  logic                   timeout_s;
  logic [EW-1:0]          head_s;
  logic [NUM_PORTS-1:0]   head_src_s;
  logic [NUM_PORTS-1:0]   head_tgt_s;
  logic [DATA_W-1:0]      head_data_s;
  logic [1:0]             head_type_s;
  logic                   head_valid_s;

  function automatic logic is_onehot(input logic [NUM_PORTS-1:0] v);
    return (v != '0) && ((v & (v - NUM_PORTS'(1))) == '0);
  endfunction

  function automatic logic [1:0] classify(input logic [NUM_PORTS-1:0] src,
                                          input logic [NUM_PORTS-1:0] tgt);
    if (!is_onehot(src) || (tgt == '0) || ((tgt & src) != '0)) begin
      return PT_ERR;
    end else if (is_onehot(tgt)) begin
      return PT_UC;
    end else if (tgt == ~src) begin
      return PT_BC;
    end else begin
      return PT_MC;
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  assign head_s       = mem_q[rd_ptr_q];
  assign head_src_s   = head_s[NUM_PORTS-1:0];
  assign head_tgt_s   = head_s[2*NUM_PORTS-1:NUM_PORTS];
  assign head_data_s  = head_s[EW-1:2*NUM_PORTS];
  assign head_type_s  = classify(head_src_s, head_tgt_s);
  assign head_valid_s = (head_type_s != PT_ERR);

  // ready_in looks only at the registered level, so a pop in a full cycle cannot admit a push
  assign ready_in  = (count_q != LW'(FIFO_DEPTH));
  assign push_s    = valid_in && ready_in;
  assign timeout_s = TO_EN && (state_q == ARB_WAIT) && !grant && (wait_q == WAIT_LAST);
  assign pop_s     = ((state_q == ROUTE) && !head_valid_s) || (state_q == TRANSMIT) || timeout_s;

  // Occupancy next-state: simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since pointers define what is live
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {data_in, target_in, source_in};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Packet-handling FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      type_q       <= PT_ERR;
      wait_q       <= '0;
      req_q        <= '0;
      valid_out_q  <= 1'b0;
      source_out_q <= '0;
      target_out_q <= '0;
      data_out_q   <= '0;
      pkt_type_q   <= PT_ERR;
      tx_cnt_q     <= '0;
      drop_cnt_q   <= '0;
    end else begin
      req_q        <= '0;
      valid_out_q  <= 1'b0;
      source_out_q <= '0;
      target_out_q <= '0;
      data_out_q   <= '0;
      pkt_type_q   <= PT_ERR;
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q <= ROUTE;
          end else begin
            state_q <= IDLE;
          end
        end
        ROUTE: begin
          type_q <= head_type_s;
          if (head_valid_s) begin
            state_q <= ARB_WAIT;
            wait_q  <= '0;
            req_q   <= head_tgt_s;
          end else begin
            state_q    <= IDLE;
            drop_cnt_q <= sat_inc(drop_cnt_q);
          end
        end
        ARB_WAIT: begin
          if (grant) begin
            state_q      <= TRANSMIT;
            valid_out_q  <= 1'b1;
            source_out_q <= head_src_s;
            target_out_q <= head_tgt_s;
            data_out_q   <= head_data_s;
            pkt_type_q   <= type_q;
          end else if (timeout_s) begin
            state_q    <= IDLE;
            drop_cnt_q <= sat_inc(drop_cnt_q);
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
            req_q  <= head_tgt_s;
          end
        end
        TRANSMIT: begin
          state_q  <= IDLE;
          tx_cnt_q <= sat_inc(tx_cnt_q);
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req          = req_q;
  assign valid_out    = valid_out_q;
  assign source_out   = source_out_q;
  assign target_out   = target_out_q;
  assign data_out     = data_out_q;
  assign pkt_type_out = pkt_type_q;
  assign tx_cnt       = tx_cnt_q;
  assign drop_cnt     = drop_cnt_q;
  assign fifo_level   = count_q;

endmodule

// File: tb/tb_switch_port_p.sv
// Directed bench for switch_port_p: u0 uses defaults, u1 has an 8-cycle
// arbitration timeout and 2-bit counters; both share the stimulus.
module tb_switch_port_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       valid_in;
  logic [3:0] source_in;
  logic [3:0] target_in;
  logic [7:0] data_in;
  logic       grant;

  logic        ready0, vo0;
  logic [3:0]  req0, so0, to0;
  logic [7:0]  do0;
  logic [1:0]  pt0;
  logic [15:0] tx0, dr0;
  logic [2:0]  lvl0;

  logic        ready1, vo1;
  logic [3:0]  req1, so1, to1;
  logic [7:0]  do1;
  logic [1:0]  pt1;
  logic [1:0]  tx1, dr1;
  logic [2:0]  lvl1;

  switch_port_p #(.NUM_PORTS(4), .DATA_W(8), .FIFO_DEPTH(4), .ARB_TIMEOUT(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready0),
    .source_in(source_in), .target_in(target_in), .data_in(data_in),
    .req(req0), .grant(grant), .valid_out(vo0), .source_out(so0), .target_out(to0),
    .data_out(do0), .pkt_type_out(pt0), .tx_cnt(tx0), .drop_cnt(dr0), .fifo_level(lvl0)
  );

  switch_port_p #(.NUM_PORTS(4), .DATA_W(8), .FIFO_DEPTH(4), .ARB_TIMEOUT(8), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready1),
    .source_in(source_in), .target_in(target_in), .data_in(data_in),
    .req(req1), .grant(grant), .valid_out(vo1), .source_out(so1), .target_out(to1),
    .data_out(do1), .pkt_type_out(pt1), .tx_cnt(tx1), .drop_cnt(dr1), .fifo_level(lvl1)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] full_tgt [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0110, 4'b1110};
  logic [1:0] full_typ [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
  logic [3:0] ty_src   [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b1000};
  logic [3:0] ty_tgt   [5] = '{4'b1110, 4'b0110, 4'b0100, 4'b0001, 4'b0111};
  logic [1:0] ty_typ   [5] = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b11};
  logic [1:0] ty_tx    [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
    source_in = s;
    target_in = t;
    data_in   = d;
    valid_in  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit got;

    rst_n = 1'b0; valid_in = 1'b0; source_in = '0; target_in = '0; data_in = '0; grant = 1'b0;
    tick; tick;
    chk("rst_ready0", ready0, 1);
    chk("rst_level0", lvl0, 0);
    chk("rst_req0", req0, 0);
    chk("rst_valid0", vo0, 0);
    chk("rst_tx0", tx0, 0);
    chk("rst_drop0", dr0, 0);
    chk("rst_ready1", ready1, 1);
    rst_n = 1'b1;
    tick;

    // Unicast with grant tied high: req one cycle, valid_out in the 4th cycle after the push edge
    grant = 1'b1;
    drive_pkt(4'b0001, 4'b0100, 8'hA5);
    tick; valid_in = 1'b0;
    chk("uc_level", lvl0, 1);
    chk("uc_req_c1", req0, 0);
    tick;
    chk("uc_req_c2", req0, 0);
    tick;
    chk("uc_req_c3", req0, 4'b0100);
    chk("uc_valid_c3", vo0, 0);
    tick;
    chk("uc_valid", vo0, 1);
    chk("uc_src", so0, 4'b0001);
    chk("uc_tgt", to0, 4'b0100);
    chk("uc_data", do0, 8'hA5);
    chk("uc_type", pt0, 2'b01);
    chk("uc_req_tx", req0, 0);
    tick;
    chk("uc_valid_after", vo0, 0);
    chk("uc_src_after", so0, 0);
    chk("uc_txcnt", tx0, 1);
    chk("uc_level_after", lvl0, 0);

    // Invalid packet (two source bits) is dropped silently
    drive_pkt(4'b0011, 4'b0100, 8'h5A);
    tick; valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("inv_req%0d", i), req0, 0);
      chk($sformatf("inv_valid%0d", i), vo0, 0);
      tick;
    end
    chk("inv_drop", dr0, 1);
    chk("inv_level", lvl0, 0);
    chk("inv_tx", tx0, 1);

    // Full FIFO: five back-to-back pushes with grant low, fifth is refused
    grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_pkt(4'b0001, full_tgt[i], 8'(8'h10 + i));
      chk($sformatf("full_ready%0d", i), ready0, (i < 4) ? 1 : 0);
      tick;
    end
    valid_in = 1'b0;
    chk("full_level", lvl0, 4);
    chk("full_ready_hold", ready0, 0);
    chk("full_req", req0, 4'b0010);
    chk("full_valid", vo0, 0);
    grant = 1'b1;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      if (vo0) begin
        if (k < 4) begin
          chk($sformatf("full_data%0d", k), do0, 8'(8'h10 + k));
          chk($sformatf("full_tgt%0d", k), to0, full_tgt[k]);
          chk($sformatf("full_type%0d", k), pt0, full_typ[k]);
          if (k == 0) begin
            chk("full_ready_on_pop", ready0, 0);
          end
        end else begin
          chk("full_extra_pkt", vo0, 0);
        end
        k++;
      end
      tick;
    end
    chk("full_count", k, 4);
    chk("full_level_end", lvl0, 0);
    chk("full_tx", tx0, 5);
    chk("full_drop", dr0, 1);

    // Arbitration timeout on u1: 8 waiting cycles, then drop; u0 keeps waiting
    rst_n = 1'b0; tick; rst_n = 1'b1; tick;
    grant = 1'b0;
    drive_pkt(4'b0001, 4'b0100, 8'h3C);
    tick; valid_in = 1'b0;
    tick; tick;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_req%0d", i), req1, 4'b0100);
      tick;
    end
    chk("to_req_after", req1, 0);
    chk("to_drop", dr1, 1);
    chk("to_tx", tx1, 0);
    chk("to_level", lvl1, 0);
    chk("to_disabled_req", req0, 4'b0100);
    chk("to_disabled_level", lvl0, 1);

    // Packet types and 2-bit counter saturation on u1
    rst_n = 1'b0; tick; rst_n = 1'b1; tick;
    grant = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_pkt(ty_src[i], ty_tgt[i], 8'(8'hC0 + i));
      tick; valid_in = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 10; c++) begin
        if (vo1 && !got) begin
          got = 1'b1;
          chk($sformatf("ty_type%0d", i), pt1, ty_typ[i]);
          chk($sformatf("ty_data%0d", i), do1, 8'(8'hC0 + i));
        end
        tick;
      end
      chk($sformatf("ty_seen%0d", i), got, 1);
      chk($sformatf("ty_tx%0d", i), tx1, ty_tx[i]);
    end
    chk("ty_tx_wide", tx0, 5);

    // Reset in ARB_WAIT with three queued entries clears everything immediately
    grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_pkt(4'b0001, 4'b0010, 8'(8'h70 + i));
      tick;
    end
    valid_in = 1'b0;
    tick;
    chk("mr_req_before", req0, 4'b0010);
    chk("mr_level_before", lvl0, 3);
    rst_n = 1'b0;
    #1;
    chk("mr_req", req0, 0);
    chk("mr_level", lvl0, 0);
    chk("mr_tx", tx0, 0);
    chk("mr_drop", dr0, 0);
    chk("mr_ready", ready0, 1);
    chk("mr_tx1", tx1, 0);
    tick; rst_n = 1'b1; tick;
    grant = 1'b1;
    drive_pkt(4'b0100, 4'b0001, 8'h9E);
    tick; valid_in = 1'b0;
    tick; tick; tick;
    chk("mr_post_valid", vo0, 1);
    chk("mr_post_data", do0, 8'h9E);
    chk("mr_post_src", so0, 4'b0100);
    tick;
    chk("mr_post_tx", tx0, 1);
    chk("mr_post_level", lvl0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
